// File: rtl/acq_channel_scheduler.sv
// Purpose: round-robin packetiser from two ADC sample FIFOs into the USB upload FIFO (header, PKT_LEN samples, XOR trailer).
// Latency: header is written the cycle after a channel is seen eligible in IDLE; a packet is PKT_LEN+2 write cycles plus >=1 IDLE cycle.
// Backpressure: usb_fifo_full freezes the FSM with no write and no read strobes; it resumes the cycle full drops.
module acq_channel_scheduler #(
  parameter int         PKT_LEN = 256,
  parameter int         LEVEL_W = 11,
  parameter logic [3:0] HDR_TAG = 4'hC,
  parameter logic [3:0] TRL_TAG = 4'hE
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [1:0]         Channel_Select,
  input  logic               flush,
  input  logic [LEVEL_W-1:0] ch1_level,
  input  logic [15:0]        ch1_data,
  output logic               ch1_rden,
  input  logic [LEVEL_W-1:0] ch2_level,
  input  logic [15:0]        ch2_data,
  output logic               ch2_rden,
  input  logic               usb_fifo_full,
  output logic               usb_fifo_wren,
  output logic [15:0]        usb_fifo_data,
  output logic               busy,
  output logic [15:0]        pkt_count
);

  // The trailer tag is reserved for the host parser; the header tag is kept
  // distinct from it so a header can never be mistaken for a tagged trailer.
  localparam logic [3:0]         HDR_TAG_EFF = (HDR_TAG == TRL_TAG) ? ~TRL_TAG : HDR_TAG;
  localparam logic [LEVEL_W-1:0] PKT_LEVEL   = LEVEL_W'(PKT_LEN);
  localparam logic [9:0]         LAST_WORD   = 10'(PKT_LEN - 1);

  typedef enum logic [1:0] {IDLE, HEADER, BURST, TRAILER} state_t;

  state_t      state;
  state_t      state_nxt;

  // grant / last_grant: 0 = ch1, 1 = ch2
  logic        grant;
  logic        last_grant;
  logic        grant_nxt;
  logic [9:0]  seq1;
  logic [9:0]  seq2;
  logic [9:0]  word_cnt;
  logic [15:0] checksum;

  logic        elig1;
  logic        elig2;
  logic        do_grant;
  logic        do_word;
  logic        do_close;
  logic [15:0] cur_data;
  logic [9:0]  cur_seq;

  assign elig1    = Channel_Select[0] && (ch1_level >= PKT_LEVEL);
  assign elig2    = Channel_Select[1] && (ch2_level >= PKT_LEVEL);
  // Both eligible: take the one not served last; otherwise the only eligible one.
  assign grant_nxt = (elig1 && elig2) ? ~last_grant : (elig2 && !elig1);
  assign cur_data = grant ? ch2_data : ch1_data;
  assign cur_seq  = grant ? seq2 : seq1;
  assign busy     = (state != IDLE);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next state and strobes; flush overrides every FSM action and silences strobes at once.
  always_comb begin
    state_nxt     = state;
    usb_fifo_wren = 1'b0;
    usb_fifo_data = 16'h0000;
    ch1_rden      = 1'b0;
    ch2_rden      = 1'b0;
    do_grant      = 1'b0;
    do_word       = 1'b0;
    do_close      = 1'b0;
    if (flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE: begin
          if (elig1 || elig2) begin
            do_grant  = 1'b1;
            state_nxt = HEADER;
          end
        end
        HEADER: begin
          usb_fifo_data = {HDR_TAG_EFF, (grant ? 2'b10 : 2'b01), cur_seq};
          if (!usb_fifo_full) begin
            usb_fifo_wren = 1'b1;
            state_nxt     = BURST;
          end
        end
        BURST: begin
          usb_fifo_data = cur_data;
          if (!usb_fifo_full) begin
            usb_fifo_wren = 1'b1;
            ch1_rden      = !grant;
            ch2_rden      = grant;
            do_word       = 1'b1;
            if (word_cnt == LAST_WORD) begin
              state_nxt = TRAILER;
            end
          end
        end
        TRAILER: begin
          usb_fifo_data = checksum;
          if (!usb_fifo_full) begin
            usb_fifo_wren = 1'b1;
            do_close      = 1'b1;
            state_nxt     = IDLE;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  // Grant bookkeeping, running checksum, word counter and per-channel sequence numbers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      grant      <= 1'b0;
      last_grant <= 1'b1;
      seq1       <= 10'd0;
      seq2       <= 10'd0;
      word_cnt   <= 10'd0;
      checksum   <= 16'h0000;
    end else if (flush) begin
      last_grant <= 1'b1;
      seq1       <= 10'd0;
      seq2       <= 10'd0;
      word_cnt   <= 10'd0;
      checksum   <= 16'h0000;
    end else begin
      if (do_grant) begin
        grant      <= grant_nxt;
        last_grant <= grant_nxt;
        word_cnt   <= 10'd0;
        checksum   <= 16'h0000;
      end
      if (do_word) begin
        word_cnt <= word_cnt + 10'd1;
        checksum <= checksum ^ cur_data;
      end
      if (do_close) begin
        if (grant) begin
          seq2 <= seq2 + 10'd1;
        end else begin
          seq1 <= seq1 + 10'd1;
        end
      end
    end
  end

  // Completed-packet counter; survives flush and wraps naturally.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pkt_count <= 16'h0000;
    end else if (do_close) begin
      pkt_count <= pkt_count + 16'h0001;
    end
  end

endmodule

// File: tb/tb_acq_channel_scheduler.sv
// Bench for acq_channel_scheduler with PKT_LEN=4: vector table, corner-case sequences,
// and a randomized run scored against a packet-level reference model.
module tb_acq_channel_scheduler;

  localparam int P = 4;

  logic        clk;
  logic        reset;
  logic [1:0]  Channel_Select;
  logic        flush;
  logic [10:0] ch1_level;
  logic [15:0] ch1_data;
  logic        ch1_rden;
  logic [10:0] ch2_level;
  logic [15:0] ch2_data;
  logic        ch2_rden;
  logic        usb_fifo_full;
  logic        usb_fifo_wren;
  logic [15:0] usb_fifo_data;
  logic        busy;
  logic [15:0] pkt_count;

  acq_channel_scheduler #(
    .PKT_LEN(P),
    .LEVEL_W(11),
    .HDR_TAG(4'hC),
    .TRL_TAG(4'hE)
  ) dut (
    .clk(clk),
    .reset(reset),
    .Channel_Select(Channel_Select),
    .flush(flush),
    .ch1_level(ch1_level),
    .ch1_data(ch1_data),
    .ch1_rden(ch1_rden),
    .ch2_level(ch2_level),
    .ch2_data(ch2_data),
    .ch2_rden(ch2_rden),
    .usb_fifo_full(usb_fifo_full),
    .usb_fifo_wren(usb_fifo_wren),
    .usb_fifo_data(usb_fifo_data),
    .busy(busy),
    .pkt_count(pkt_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;

  // channel FIFO stand-ins and expected sample streams
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic [15:0] mq1[$];
  logic [15:0] mq2[$];

  // samples taken at the falling edge
  logic        s_wren, s_r1, s_r2, s_busy, s_full;
  logic [15:0] s_data, s_pkt;
  logic [1:0]  s_sel;
  logic [10:0] s_l1, s_l2;

  // reference model state
  bit          mon_en = 0;
  int          m_idx, m_ch, m_last;
  int          m_seq[2];
  logic [15:0] m_xor, m_pkts;
  logic [1:0]  snap_sel;
  logic [10:0] snap_l1, snap_l2;

  typedef struct {
    logic [1:0]  sel;
    logic        full;
    logic        exp_wren;
    logic [15:0] exp_data;
    logic        exp_r1;
    logic        exp_busy;
    logic [15:0] exp_pkt;
  } vec_t;

  vec_t vecs[19];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, exp);
  endtask

  task automatic refresh();
    ch1_level = 11'(q1.size());
    ch2_level = 11'(q2.size());
    ch1_data  = (q1.size() > 0) ? q1[0] : 16'h0000;
    ch2_data  = (q2.size() > 0) ? q2[0] : 16'h0000;
  endtask

  task automatic model_check();
    logic [15:0] w;
    logic [15:0] hdr;
    bit e1, e2;
    int ch;
    chk("rand pkt_count", s_pkt, m_pkts);
    if (!s_busy) begin
      snap_sel = s_sel; snap_l1 = s_l1; snap_l2 = s_l2;
      chk("rand idle quiet", {s_wren, s_r1, s_r2}, 0);
    end else if (s_full) begin
      chk("rand stall quiet", {s_wren, s_r1, s_r2}, 0);
    end
    if (s_wren) begin
      if (m_idx == 0) begin
        e1 = snap_sel[0] && (snap_l1 >= P);
        e2 = snap_sel[1] && (snap_l2 >= P);
        if (e1 && e2) ch = (m_last == 2) ? 1 : 2;
        else ch = e1 ? 1 : 2;
        hdr = 16'(32'hC000 + (ch << 10) + m_seq[ch-1]);
        chk("rand header", s_data, hdr);
        chk("rand header rden", {s_r1, s_r2}, 0);
        m_ch = ch; m_last = ch; m_xor = 16'h0; m_idx = 1;
      end else if (m_idx <= P) begin
        if (m_ch == 1) w = (mq1.size() > 0) ? mq1.pop_front() : 16'hDEAD;
        else           w = (mq2.size() > 0) ? mq2.pop_front() : 16'hDEAD;
        chk("rand word", s_data, w);
        chk("rand word rden", {s_r1, s_r2}, (m_ch == 1) ? 2'b10 : 2'b01);
        m_xor = m_xor ^ w;
        m_idx++;
      end else begin
        chk("rand trailer", s_data, m_xor);
        m_seq[m_ch-1] = (m_seq[m_ch-1] + 1) % 1024;
        m_pkts = m_pkts + 16'd1;
        m_idx = 0;
      end
    end
  endtask

  // one clock: sample at the falling edge, then model the channel FIFO pops
  task automatic step();
    @(negedge clk);
    s_wren = usb_fifo_wren; s_data = usb_fifo_data;
    s_r1 = ch1_rden; s_r2 = ch2_rden; s_busy = busy; s_pkt = pkt_count;
    s_full = usb_fifo_full; s_sel = Channel_Select; s_l1 = ch1_level; s_l2 = ch2_level;
    if (mon_en) model_check();
    @(posedge clk);
    #1;
    if (s_r1 && q1.size() > 0) void'(q1.pop_front());
    if (s_r2 && q2.size() > 0) void'(q2.pop_front());
    refresh();
  endtask

  task automatic next_write(input string nm, output logic [15:0] d);
    int n = 0;
    do begin
      step();
      n++;
    end while (!s_wren && n < 40);
    chk({nm, " wren"}, 32'(s_wren), 1);
    d = s_data;
  endtask

  task automatic do_reset();
    reset = 1'b1; flush = 1'b0; usb_fifo_full = 1'b0; Channel_Select = 2'b00;
    q1.delete(); q2.delete(); mq1.delete(); mq2.delete();
    refresh();
    @(posedge clk);
    @(posedge clk);
    #1 reset = 1'b0;
    m_idx = 0; m_ch = 1; m_last = 2; m_seq[0] = 0; m_seq[1] = 0;
    m_xor = 16'h0; m_pkts = 16'h0; snap_sel = 2'b00; snap_l1 = '0; snap_l2 = '0;
  endtask

  task automatic push1(input logic [15:0] w);
    q1.push_back(w);
    refresh();
  endtask

  initial begin
    logic [15:0] d;
    logic [15:0] hdrs[3];
    int cnt;

    //         sel    full  wren  data      r1    busy  pkt
    vecs[0]  = '{2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd0};
    vecs[1]  = '{2'b01, 1'b0, 1'b1, 16'hC400, 1'b0, 1'b1, 16'd0};
    vecs[2]  = '{2'b01, 1'b0, 1'b1, 16'h0011, 1'b1, 1'b1, 16'd0};
    vecs[3]  = '{2'b01, 1'b0, 1'b1, 16'h0022, 1'b1, 1'b1, 16'd0};
    vecs[4]  = '{2'b01, 1'b0, 1'b1, 16'h0044, 1'b1, 1'b1, 16'd0};
    vecs[5]  = '{2'b01, 1'b0, 1'b1, 16'h0088, 1'b1, 1'b1, 16'd0};
    vecs[6]  = '{2'b01, 1'b0, 1'b1, 16'h00FF, 1'b0, 1'b1, 16'd0};
    vecs[7]  = '{2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd1};
    vecs[8]  = '{2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd1};
    vecs[9]  = '{2'b01, 1'b0, 1'b1, 16'hC401, 1'b0, 1'b1, 16'd1};
    vecs[10] = '{2'b01, 1'b0, 1'b1, 16'h1234, 1'b1, 1'b1, 16'd1};
    vecs[11] = '{2'b01, 1'b0, 1'b1, 16'h00F0, 1'b1, 1'b1, 16'd1};
    vecs[12] = '{2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd1};
    vecs[13] = '{2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd1};
    vecs[14] = '{2'b01, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b1, 16'd1};
    vecs[15] = '{2'b01, 1'b0, 1'b1, 16'hAAAA, 1'b1, 1'b1, 16'd1};
    vecs[16] = '{2'b01, 1'b0, 1'b1, 16'h5555, 1'b1, 1'b1, 16'd1};
    vecs[17] = '{2'b01, 1'b0, 1'b1, 16'hED3B, 1'b0, 1'b1, 16'd1};
    vecs[18] = '{2'b01, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0, 16'd2};

    // reset state
    do_reset();
    chk("reset wren", usb_fifo_wren, 0);
    chk("reset data", usb_fifo_data, 0);
    chk("reset rden", {ch1_rden, ch2_rden}, 0);
    chk("reset busy", busy, 0);
    chk("reset pkt_count", pkt_count, 0);

    // single channel packet, then a stalled one
    push1(16'h0011); push1(16'h0022); push1(16'h0044); push1(16'h0088);
    for (int i = 0; i < 19; i++) begin
      if (i == 8) begin
        push1(16'h1234); push1(16'h00F0); push1(16'hAAAA); push1(16'h5555);
      end
      Channel_Select = vecs[i].sel;
      usb_fifo_full  = vecs[i].full;
      refresh();
      step();
      chk($sformatf("vec%0d wren", i), s_wren, vecs[i].exp_wren);
      if (vecs[i].exp_wren || !vecs[i].exp_busy)
        chk($sformatf("vec%0d data", i), s_data, vecs[i].exp_data);
      chk($sformatf("vec%0d ch1_rden", i), s_r1, vecs[i].exp_r1);
      chk($sformatf("vec%0d ch2_rden", i), s_r2, 0);
      chk($sformatf("vec%0d busy", i), s_busy, vecs[i].exp_busy);
      chk($sformatf("vec%0d pkt_count", i), s_pkt, vecs[i].exp_pkt);
    end

    // round robin with both channels always eligible
    do_reset();
    Channel_Select = 2'b11;
    for (int i = 0; i < 12; i++) begin
      q1.push_back(16'(16'h1000 + i));
      q2.push_back(16'(16'h2000 + i));
    end
    refresh();
    for (int k = 0; k < 18; k++) begin
      next_write("rr", d);
      if (k % 6 == 0) hdrs[k/6] = d;
    end
    chk("rr header 1", hdrs[0], 16'hC400);
    chk("rr header 2", hdrs[1], 16'hC800);
    chk("rr header 3", hdrs[2], 16'hC401);

    // select dropped to 00 mid-burst: packet completes, nothing new starts
    do_reset();
    Channel_Select = 2'b01;
    push1(16'h0001); push1(16'h0002); push1(16'h0003); push1(16'h0004);
    next_write("sel hdr", d);
    chk("sel header", d, 16'hC400);
    Channel_Select = 2'b00;
    for (int k = 1; k <= 4; k++) begin
      next_write("sel word", d);
      chk($sformatf("sel word%0d", k), d, 16'(k));
    end
    next_write("sel trl", d);
    chk("sel trailer", d, 16'h0004);
    push1(16'h0005); push1(16'h0006); push1(16'h0007); push1(16'h0008);
    cnt = 0;
    for (int k = 0; k < 10; k++) begin
      step();
      if (s_wren) cnt++;
    end
    chk("sel no new packet", cnt, 0);
    chk("sel busy", s_busy, 0);
    chk("sel pkt_count", s_pkt, 1);

    // flush mid-burst clears sequence numbers
    do_reset();
    Channel_Select = 2'b01;
    for (int i = 0; i < 12; i++) push1(16'(16'h0100 + i));
    for (int k = 0; k < 6; k++) next_write("fl pkt1", d);
    next_write("fl hdr2", d);
    chk("flush pre header", d, 16'hC401);
    next_write("fl w0", d);
    next_write("fl w1", d);
    flush = 1'b1;
    step();
    chk("flush wren same cycle", s_wren, 0);
    chk("flush rden same cycle", {s_r1, s_r2}, 0);
    flush = 1'b0;
    step();
    chk("flush idle next", s_busy, 0);
    next_write("fl hdr3", d);
    chk("flush post header", d, 16'hC400);
    chk("flush keeps pkt_count", s_pkt, 1);

    // sequence number wrap after 1024 packets
    do_reset();
    Channel_Select = 2'b01;
    for (int p = 0; p < 1024; p++) begin
      for (int i = 0; i < P; i++) push1(16'(p + i));
      next_write("wrap hdr", d);
      if (p == 1023) chk("wrap header 1024", d, 16'hC7FF);
      for (int k = 0; k < P + 1; k++) next_write("wrap body", d);
    end
    step();
    chk("wrap pkt_count", pkt_count, 1024);
    for (int i = 0; i < P; i++) push1(16'h00AB);
    next_write("wrap hdr1025", d);
    chk("wrap header 1025", d, 16'hC400);
    for (int k = 0; k < P + 1; k++) next_write("wrap last", d);

    // reset while a header is held off by a full USB FIFO
    usb_fifo_full = 1'b1;
    for (int i = 0; i < P; i++) push1(16'h0F0F);
    cnt = 0;
    do begin
      step();
      cnt++;
    end while (!s_busy && cnt < 10);
    chk("hold header busy", s_busy, 1);
    chk("hold header wren", s_wren, 0);
    reset = 1'b1;
    #1;
    chk("midreset wren", usb_fifo_wren, 0);
    chk("midreset data", usb_fifo_data, 0);
    chk("midreset rden", {ch1_rden, ch2_rden}, 0);
    chk("midreset busy", busy, 0);
    chk("midreset pkt_count", pkt_count, 0);
    @(posedge clk);
    #1;

    // randomized traffic against the packet-level model
    do_reset();
    mon_en = 1;
    for (int c = 0; c < 3000; c++) begin
      logic [15:0] w;
      if ($urandom_range(3) == 0) Channel_Select = 2'($urandom_range(3));
      usb_fifo_full = ($urandom_range(3) == 0);
      if (q1.size() < 40 && $urandom_range(1) == 1) begin
        w = 16'($urandom); q1.push_back(w); mq1.push_back(w);
      end
      if (q2.size() < 40 && $urandom_range(1) == 1) begin
        w = 16'($urandom); q2.push_back(w); mq2.push_back(w);
      end
      refresh();
      step();
    end
    mon_en = 0;
    chk("rand progress", 32'(m_pkts > 16'd20), 1);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
